// File: rtl/stack_bus_upstream_pe_cntl.sv
// PE-side upstream stack-bus controller.
// Buffers framed words, prepends a header and drives the upstream port.
module stack_bus_upstream_pe_cntl #(
    parameter int PE_ID      = 0,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_poweron,
    input  logic              std__stu__valid,
    input  logic [1:0]        std__stu__cntl,
    input  logic [DATA_W-1:0] std__stu__data,
    input  logic [TAG_W-1:0]  std__stu__tag,
    output logic              stu__std__ready,
    output logic              pe__sys__stack_upstream_valid,
    output logic [1:0]        pe__sys__stack_upstream_cntl,
    output logic [DATA_W-1:0] pe__sys__stack_upstream_data,
    input  logic              sys__pe__stack_upstream_ready,
    output logic [7:0]        stu__cfg__err_count,
    output logic [7:0]        stu__cfg__pkt_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 2 + TAG_W + DATA_W;

    localparam logic [1:0] C_MOD = 2'b00;
    localparam logic [1:0] C_SOD = 2'b01;
    localparam logic [1:0] C_EOD = 2'b10;
    localparam logic [1:0] C_SE  = 2'b11;

    localparam logic [0:0] IN_IDLE = 1'b0;
    localparam logic [0:0] IN_PKT  = 1'b1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_BODY = 2'd2;

    // FIFO storage and occupancy
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Input side
    logic          rdy_en;
    logic          in_xfer;
    logic [0:0]    in_state;
    logic [0:0]    in_state_nxt;
    logic          accept;
    logic          err_inc;

    // Output side
    logic [1:0]        out_state;
    logic [1:0]        out_state_nxt;
    logic              out_valid;
    logic [1:0]        out_cntl;
    logic [DATA_W-1:0] out_data;
    logic              v_nxt;
    logic [1:0]        c_nxt;
    logic [DATA_W-1:0] d_nxt;
    logic              load;
    logic              eod_acc;
    logic [7:0]        pkt_count;
    logic [7:0]        pkt_nxt;
    logic [7:0]        err_count;

    // FIFO head fields
    logic [EW-1:0]     head;
    logic [1:0]        head_cntl;
    logic [TAG_W-1:0]  head_tag;
    logic [DATA_W-1:0] head_data;
    logic [7:0]        tag8;
    logic [31:0]       hdr32;

    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);

    assign stu__std__ready = rdy_en & ~full;
    assign in_xfer = std__stu__valid & stu__std__ready;

    assign head      = mem[rd_ptr];
    assign head_cntl = head[EW-1 -: 2];
    assign head_tag  = head[DATA_W +: TAG_W];
    assign head_data = head[DATA_W-1:0];

    assign load    = ~out_valid | sys__pe__stack_upstream_ready;
    assign eod_acc = out_valid & sys__pe__stack_upstream_ready & out_cntl[1];
    assign pkt_nxt = pkt_count + {7'd0, eod_acc};

    // The header of a packet that follows an EOD accepted this cycle
    // must already carry the incremented sequence number.
    assign tag8  = 8'(head_tag);
    assign hdr32 = {8'(PE_ID), tag8, pkt_nxt, 8'h00};

    assign pe__sys__stack_upstream_valid = out_valid;
    assign pe__sys__stack_upstream_cntl  = out_cntl;
    assign pe__sys__stack_upstream_data  = out_data;
    assign stu__cfg__err_count = err_count;
    assign stu__cfg__pkt_count = pkt_count;

    // Framing checker: decide push or drop for each accepted word
    always_comb begin
        accept       = 1'b0;
        err_inc      = 1'b0;
        in_state_nxt = in_state;
        if (in_xfer) begin
            if (in_state == IN_IDLE) begin
                unique case (std__stu__cntl)
                    C_SOD: begin
                        accept       = 1'b1;
                        in_state_nxt = IN_PKT;
                    end
                    C_SE:    accept  = 1'b1;
                    default: err_inc = 1'b1;
                endcase
            end else begin
                unique case (std__stu__cntl)
                    C_MOD: accept = 1'b1;
                    C_EOD: begin
                        accept       = 1'b1;
                        in_state_nxt = IN_IDLE;
                    end
                    default: err_inc = 1'b1;
                endcase
            end
        end
    end

    assign push = accept;

    // Checker state, ready enable and saturating error count
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            in_state  <= IN_IDLE;
            rdy_en    <= 1'b0;
            err_count <= 8'd0;
        end else begin
            in_state <= in_state_nxt;
            rdy_en   <= 1'b1;
            if (err_inc && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    // FIFO payload write; contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {std__stu__cntl, std__stu__tag, std__stu__data};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Output FSM: header insertion and body forwarding
    always_comb begin
        out_state_nxt = out_state;
        pop           = 1'b0;
        v_nxt         = out_valid;
        c_nxt         = out_cntl;
        d_nxt         = out_data;
        if (load) begin
            v_nxt = 1'b0;
            unique case (out_state)
                S_IDLE: begin
                    if (!empty) begin
                        if (head_cntl[0]) begin
                            v_nxt         = 1'b1;
                            c_nxt         = C_SOD;
                            d_nxt         = DATA_W'(hdr32);
                            out_state_nxt = S_HDR;
                        end else begin
                            // stray continuation word: discard it
                            pop = 1'b1;
                        end
                    end
                end
                S_HDR: begin
                    if (!empty) begin
                        v_nxt = 1'b1;
                        pop   = 1'b1;
                        d_nxt = head_data;
                        if (head_cntl[1]) begin
                            c_nxt         = C_EOD;
                            out_state_nxt = S_IDLE;
                        end else begin
                            c_nxt         = C_MOD;
                            out_state_nxt = S_BODY;
                        end
                    end
                end
                S_BODY: begin
                    if (!empty) begin
                        v_nxt = 1'b1;
                        pop   = 1'b1;
                        d_nxt = head_data;
                        if (head_cntl == C_EOD) begin
                            c_nxt         = C_EOD;
                            out_state_nxt = S_IDLE;
                        end else begin
                            c_nxt = C_MOD;
                        end
                    end
                end
                default: out_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output register, FSM state and packet sequence counter
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            out_state <= S_IDLE;
            out_valid <= 1'b0;
            out_cntl  <= 2'b00;
            out_data  <= '0;
            pkt_count <= 8'd0;
        end else begin
            out_state <= out_state_nxt;
            out_valid <= v_nxt;
            out_cntl  <= c_nxt;
            out_data  <= d_nxt;
            pkt_count <= pkt_nxt;
        end
    end

endmodule

// File: doc/stack_bus_upstream_pe_cntl.md
# stack_bus_upstream_pe_cntl

PE-side upstream stack-bus controller that sits directly upstream of the stack bus on each PE. It accepts framed result words from the PE streaming-ops controller and buffers them in a small FIFO. It prepends a header word carrying PE ID, tag and packet sequence number, then drives the packet onto the PE's upstream stack-bus port with a valid/ready handshake toward the manager. It also polices input framing and counts protocol violations.

## Interface
- PE_ID, 0, 8-bit PE identifier placed in header word.
- DATA_W, 32, payload word width; header layout assumes 32.
- TAG_W, 8, tag width sampled with SOD.
- FIFO_DEPTH, 8, input FIFO entries; power of 2, ≥2.

- clk  input  1  system clock; all state on rising edge.
- reset_poweron  input  1  asynchronous, active-low reset.
- std__stu__valid  input  1  input word valid.
- std__stu__cntl  input  2  framing: 2'b01 SOD, 2'b00 MOD, 2'b10 EOD, 2'b11 SOD+EOD (single-word packet).
- std__stu__data  input  DATA_W  input payload word.
- std__stu__tag  input  TAG_W  packet tag; meaningful only on SOD/SOD+EOD words.
- stu__std__ready  output  1  input ready; a word transfers when valid & ready.
- pe__sys__stack_upstream_valid  output  1  upstream word valid.
- pe__sys__stack_upstream_cntl  output  2  upstream framing, same encoding as input.
- pe__sys__stack_upstream_data  output  DATA_W  upstream word.
- sys__pe__stack_upstream_ready  input  1  upstream ready from stack bus.
- stu__cfg__err_count  output  8  saturating framing-error count.
- stu__cfg__pkt_count  output  8  sequence number of next packet; wraps.

## Operation
- Reset: FIFO empty, input checker IN_IDLE, output FSM IDLE, output register invalid. Outputs: stu__std__ready=0 while reset asserted, upstream_valid=0, cntl=0, data=0, err_count=0, pkt_count=0.
- stu__std__ready = !fifo_full (registered occupancy). It is 1 from the first edge after reset release when the FIFO is not full.
- Input checker, states IN_IDLE/IN_PKT, evaluated on each transfer:
  - IN_IDLE + SOD → push, go IN_PKT.
  - IN_IDLE + SOD+EOD → push, stay.
  - IN_IDLE + MOD or EOD → drop word, err_count++.
  - IN_PKT + MOD → push.
  - IN_PKT + EOD → push, go IN_IDLE.
  - IN_PKT + SOD or SOD+EOD → drop word, err_count++, stay IN_PKT.
  - Dropped words are still consumed, because ready is unchanged.
- FIFO entry = {cntl, tag, data}. Push and pop in the same cycle leaves occupancy unchanged.
- Output FSM (IDLE, HDR, BODY) loads a single output register whenever !upstream_valid | upstream_ready:
  - IDLE: if the FIFO head is SOD or SOD+EOD, load header {PE_ID[7:0], head tag[7:0], pkt_count[7:0], 8'h00} with cntl=SOD, without popping; go HDR.
  - HDR: once the header is accepted (load condition true), load the head data word, pop. cntl=EOD if head was SOD+EOD, else MOD. Go BODY, or to IDLE if EOD was loaded.
  - BODY: on load condition with FIFO non-empty, pop head. Load cntl=EOD if head is EOD, else MOD. After loading EOD go IDLE.
  - If the FIFO is empty at a load opportunity, upstream_valid drops to 0.
  - pkt_count increments (mod 256) on the cycle the EOD word is accepted upstream.
- Handshake: while upstream_valid=1 and upstream_ready=0, valid/cntl/data hold stable.
- err_count saturates at 255; it does not wrap.
- Reset mid-packet: all state is discarded; there is no partial-packet flush.

## Timing
- Input word accepted in cycle N is visible in the FIFO at N+1. The header is registered at the end of N+1 and visible at N+2. The first data word is visible at N+3 when ready is held high.
- In BODY with ready=1 and FIFO non-empty, throughput is 1 word/cycle.
- Per-packet overhead: 1 header cycle. Back-to-back packets have no idle cycle between EOD and the next header.
- FIFO full: ready deasserts in the cycle after the DEPTH-th push. It reasserts the cycle after the first pop.

## Test plan
- Single 4-word packet (SOD,MOD,MOD,EOD; tag 0x3C; data 0x11..0x44), PE_ID=5, ready=1 → upstream header 0x053C0000 (SOD), then 0x11 MOD, 0x22 MOD, 0x33 MOD, 0x44 EOD. Header at N+2, pkt_count 0→1.
- SOD+EOD single word 0xDEAD, tag 0x07 → header 0x05070100 SOD, then 0xDEAD EOD. pkt_count 1→2.
- Backpressure: upstream_ready=0 for 20 cycles during a 12-word packet → ready drops after 8 buffered words, output held stable, no loss or duplication after release.
- Framing errors: MOD while idle, then SOD, SOD, EOD → err_count=2. Only the first SOD and the EOD forwarded. Drive 300 errors → err_count=255.
- Sequence wrap: 257 packets → header seq fields run 0..255,0; pkt_count=1 at end.
- Reset asserted mid-body → outputs 0 asynchronously, counts 0. A new packet after release starts with header seq 0.
